fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS-32 pipeline, sitting between the program-counter register and decode. Each cycle it takes the current PC, requests the instruction from instruction memory over a req/ack handshake, and computes the next PC to feed back into the PC register: hold, PC+4, or branch/jump redirect. It also owns the IF/ID pipeline register, handling decode back-pressure and redirect flushes.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 16 +
 rtl/if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 pipeline definitions used by the fetch stage and its neighbours.
package mips_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned PC_INC       = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch (master) and memory (slave).
interface fetch_stage_if
  import mips_pkg::*;
#(
  parameter int SIZE = 32
);

  logic               imem_req;
  logic [SIZE-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, stall-hold and flush; flush wins over load.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic               i_stall,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [SIZE-1:0]    i_pc,
  input  logic [SIZE-1:0]    i_pc_plus4,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [SIZE-1:0]    o_pc,
  output logic [SIZE-1:0]    o_pc_plus4
);

  // Pipeline register update; without a load, a stalled decode keeps the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_instr    <= '0;
      o_pc       <= '0;
      o_pc_plus4 <= SIZE'(PC_INC);
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid    <= 1'b1;
      o_instr    <= i_instr;
      o_pc       <= i_pc;
      o_pc_plus4 <= i_pc_plus4;
    end else if (!i_stall) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= o_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS-32 instruction fetch: next-PC selection, imem handshake and IF/ID ownership.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SIZE-1:0]    pc,
  output logic [SIZE-1:0]    next_pc,
  fetch_stage_if.master      imem,
  input  logic               redirect_valid,
  input  logic [SIZE-1:0]    redirect_target,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [SIZE-1:0]    if_pc,
  output logic [SIZE-1:0]    if_pc_plus4
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [INSTR_W-1:0] r_buf;
  logic [SIZE-1:0]    r_drain_addr;
  logic               w_slot_free;
  logic               w_load;
  logic               w_buf_load;
  logic               w_drain_load;
  logic [INSTR_W-1:0] w_load_instr;
  logic [SIZE-1:0]    w_pc_plus4;
  logic [SIZE-1:0]    w_redirect_pc;

  assign w_pc_plus4    = pc + SIZE'(PC_INC);
  assign w_redirect_pc = redirect_target & {{(SIZE-2){1'b1}}, 2'b00};
  assign w_slot_free   = !if_valid || !id_stall;

  // Next-state, next-PC and handshake decode; a redirect outranks every other event.
  always_comb begin
    w_state_nxt    = r_state;
    next_pc        = pc;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    w_load         = 1'b0;
    w_load_instr   = imem.imem_rdata;
    w_buf_load     = 1'b0;
    w_drain_load   = 1'b0;
    if (rst) begin
      next_pc     = RESET_VECTOR;
      w_state_nxt = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          imem.imem_req = 1'b1;
          if (redirect_valid) begin
            next_pc = w_redirect_pc;
            if (imem.imem_ack) begin
              w_state_nxt = FETCH;
            end else begin
              w_state_nxt  = DRAIN;
              w_drain_load = 1'b1;
            end
          end else if (imem.imem_ack) begin
            if (w_slot_free) begin
              w_load  = 1'b1;
              next_pc = w_pc_plus4;
            end else begin
              w_buf_load  = 1'b1;
              w_state_nxt = HOLD;
            end
          end else begin
            next_pc = pc;
          end
        end
        HOLD: begin
          w_load_instr = r_buf;
          if (redirect_valid) begin
            next_pc     = w_redirect_pc;
            w_state_nxt = FETCH;
          end else if (!id_stall) begin
            w_load      = 1'b1;
            next_pc     = w_pc_plus4;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = HOLD;
          end
        end
        DRAIN: begin
          // The request already on the bus must complete before the target is fetched.
          imem.imem_req  = 1'b1;
          imem.imem_addr = r_drain_addr;
          if (redirect_valid) begin
            next_pc = w_redirect_pc;
          end else if (imem.imem_ack) begin
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = DRAIN;
          end
        end
        default: begin
          w_state_nxt = FETCH;
        end
      endcase
    end
  end

  // FSM state, hold buffer and latched drain address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_buf        <= '0;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_buf_load) begin
        r_buf <= imem.imem_rdata;
      end
      if (w_drain_load) begin
        r_drain_addr <= pc;
      end
    end
  end

  if_id_reg #(
    .SIZE (SIZE)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (redirect_valid),
    .i_stall    (id_stall),
    .i_instr    (w_load_instr),
    .i_pc       (pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_valid    (if_valid),
    .o_instr    (if_instr),
    .o_pc       (if_pc),
    .o_pc_plus4 (if_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random stall/redirect/reset traffic
// against an in-order program-stream reference and a wait-state memory model.
module tb_fetch_stage;

  localparam int SIZE = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  fetch_stage_if #(.SIZE(SIZE)) imem ();

  fetch_stage #(.SIZE(SIZE), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .next_pc         (next_pc),
    .imem            (imem),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
  );

  always #5 clk = ~clk;

  // PC register of the surrounding pipeline.
  always_ff @(posedge clk) begin
    pc <= rst ? 32'h0000_0000 : next_pc;
  end

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_delivered = 0;
  int          wait_lo = 0;
  int          wait_hi = 0;
  int          wait_left = 0;
  bit          busy = 1'b0;
  logic [31:0] exp_pc = 32'h0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Memory with a per-request random number of wait states in [wait_lo, wait_hi].
  task automatic mem_respond();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
    if (rst) begin
      busy = 1'b0;
    end else if (imem.imem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        wait_left = $urandom_range(wait_hi, wait_lo);
      end
      if (wait_left == 0) begin
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = mem_word(imem.imem_addr);
        busy            = 1'b0;
      end else begin
        wait_left--;
      end
    end
  endtask

  // Reference: decode must see the program stream in order, restarting at each redirect target.
  task automatic scoreboard();
    if (rst) begin
      check_value("rst_next_pc", next_pc, 32'h0);
      check_value("rst_req", 32'(imem.imem_req), 32'd0);
      exp_pc = 32'h0;
    end else begin
      if (prev_req && !prev_ack && !prev_rst) begin
        check_value("req_stable", 32'(imem.imem_req), 32'd1);
        check_value("addr_stable", imem.imem_addr, prev_addr);
      end
      if (prev_redir && !prev_rst) check_value("flushed", 32'(if_valid), 32'd0);
      if (if_valid && !id_stall && !redirect_valid) begin
        check_value("issue_pc", if_pc, exp_pc);
        check_value("issue_instr", if_instr, mem_word(if_pc));
        check_value("issue_plus4", if_pc_plus4, if_pc + 32'd4);
        exp_pc = if_pc + 32'd4;
        n_delivered++;
      end
      if (redirect_valid) begin
        check_value("redir_next_pc", next_pc, redirect_target & 32'hFFFF_FFFC);
        exp_pc = redirect_target & 32'hFFFF_FFFC;
      end
    end
    prev_req   = imem.imem_req;
    prev_ack   = imem.imem_ack;
    prev_addr  = imem.imem_addr;
    prev_rst   = rst;
    prev_redir = redirect_valid;
  endtask

  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst             = r;
    id_stall        = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    mem_respond();
    #2;
    scoreboard();
  endtask

  initial begin
    logic        r_rnd;
    logic        s_rnd;
    logic        rv_rnd;
    logic [31:0] drain_addr;
    rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Zero-wait streaming from reset
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (k == 0) begin
        check_value("rst_if_valid", 32'(if_valid), 32'd0);
        check_value("rst_if_instr", if_instr, 32'h0);
        check_value("rst_if_pc", if_pc, 32'h0);
        check_value("rst_if_plus4", if_pc_plus4, 32'h4);
      end else begin
        check_value("zw_valid", 32'(if_valid), 32'd1);
        check_value("zw_if_pc", if_pc, 32'(4 * (k - 1)));
      end
      check_value("zw_addr", imem.imem_addr, 32'(4 * k));
      check_value("zw_next_pc", next_pc, 32'(4 * k + 4));
    end

    // Decode stall while the 0x10 fetch completes
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_value("st_addr", imem.imem_addr, 32'h10);
    check_value("st_next_pc", next_pc, 32'h10);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check_value("hold_req", 32'(imem.imem_req), 32'd0);
      check_value("hold_next_pc", next_pc, 32'h10);
      check_value("hold_if_pc", if_pc, 32'hC);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("unst_next_pc", next_pc, 32'h14);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("unst_if_pc", if_pc, 32'h10);
    check_value("unst_addr", imem.imem_addr, 32'h14);
    check_value("unst_req", 32'(imem.imem_req), 32'd1);

    // Two wait states, redirect in the first wait cycle
    wait_lo = 2; wait_hi = 2;
    step(1'b0, 1'b0, 1'b1, 32'h100);
    drain_addr = imem.imem_addr;
    check_value("dr_ack0", 32'(imem.imem_ack), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("dr_addr", imem.imem_addr, drain_addr);
    check_value("dr_req", 32'(imem.imem_req), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("dr_ack", 32'(imem.imem_ack), 32'd1);
    check_value("dr_next_pc", next_pc, 32'h100);
    check_value("dr_valid", 32'(if_valid), 32'd0);
    wait_lo = 0; wait_hi = 0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("dr_new_addr", imem.imem_addr, 32'h100);
    check_value("dr_valid2", 32'(if_valid), 32'd0);

    // Redirect, ack and stall together
    step(1'b0, 1'b1, 1'b1, 32'h102);
    check_value("ra_ack", 32'(imem.imem_ack), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("ra_addr", imem.imem_addr, 32'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("ra_if_pc", if_pc, 32'h100);

    // PC wrap-around
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
    check_value("wr_next_pc", next_pc, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("wr_if_pc", if_pc, 32'hFFFF_FFFC);
    check_value("wr_plus4", if_pc_plus4, 32'h0);

    // Reset in the middle of HOLD
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_value("rh_next_pc", next_pc, 32'h4);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_value("rh_req", 32'(imem.imem_req), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_value("rh_if_valid", 32'(if_valid), 32'd0);
    check_value("rh_if_instr", if_instr, 32'h0);
    check_value("rh_if_plus4", if_pc_plus4, 32'h4);
    check_value("rh_req_fetch", 32'(imem.imem_req), 32'd1);
    check_value("rh_addr", imem.imem_addr, 32'h0);

    // Random traffic
    wait_lo = 0; wait_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      r_rnd  = ($urandom_range(199, 0) == 0);
      s_rnd  = ($urandom_range(9, 0) < 3);
      rv_rnd = ($urandom_range(19, 0) == 0);
      step(r_rnd, s_rnd, rv_rnd, $urandom);
    end
    check_value("liveness", 32'(n_delivered > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
